post_normalize_round: RTL

- Back end of the FP add/sub datapath. Consumes the raw signed-magnitude mantissa sum produced after operand alignment and the adder.
- Normalizes the sum, adjusting the exponent for a carry-out (right shift) or for cancellation (left shift via leading-zero count).
- Rounds to nearest, ties to even, and packs the IEEE-754 result.
- Two-stage pipeline with a valid chain; no back-pressure.

---
 rtl/post_normalize_round.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/post_normalize_round.sv
// Post-add normalizer and round-to-nearest-even packer for the FP add/sub datapath.
// Stage 1 normalizes the raw sum; stage 2 rounds, detects overflow and packs the IEEE-754 word.
module post_normalize_round #(
    parameter int PRECISION = 32,
    localparam int EXPONENT_WIDTH = (PRECISION == 64) ? 11 : 8,
    localparam int MANTISSA_WIDTH = (PRECISION == 64) ? 52 : 23
) (
    input  logic                        I_Clk,
    input  logic                        I_nReset,
    input  logic                        I_Valid,
    input  logic                        I_Sign,
    input  logic [EXPONENT_WIDTH-1:0]   I_Exp,
    input  logic [MANTISSA_WIDTH+1:0]   I_Mantissa,
    input  logic                        I_Guard,
    input  logic                        I_Round,
    input  logic                        I_Sticky,
    output logic                        O_PostNorm_Valid,
    output logic [PRECISION-1:0]        O_PostNorm_Result,
    output logic                        O_PostNorm_Overflow,
    output logic                        O_PostNorm_Underflow,
    output logic                        O_PostNorm_Inexact
);

    localparam int EW  = EXPONENT_WIDTH;
    localparam int MW  = MANTISSA_WIDTH;
    localparam int IEW = EW + 2;
    localparam int LZW = $clog2(MW + 2);

    localparam logic signed [IEW-1:0] EXP_ONE = IEW'(1);
    localparam logic signed [IEW-1:0] EXP_MAX = IEW'((1 << EW) - 1);

    function automatic logic [LZW-1:0] lzc(input logic [MW:0] v);
        logic [LZW-1:0] n;
        n = LZW'(MW + 1);
        for (int i = 0; i <= MW; i++) begin
            if (v[i]) n = LZW'(MW - i);
        end
        return n;
    endfunction

    // Returns {carry_out, fraction} after the nearest-even increment.
    function automatic logic [MW:0] round_frac(input logic [MW-1:0] frac,
                                               input logic g, input logic r, input logic s);
        logic inc;
        inc = g & (r | s | frac[0]);
        return {1'b0, frac} + {{MW{1'b0}}, inc};
    endfunction

    function automatic logic saturates(input logic signed [IEW-1:0] e);
        return e >= EXP_MAX;
    endfunction

    logic                  carry_p0;
    logic [LZW-1:0]        lz_p0;
    logic signed [IEW-1:0] exp_in_p0;
    logic signed [IEW-1:0] lz_s_p0;
    logic [MW-1:0]         frac_shl_p0;

    logic signed [IEW-1:0] exp_n_p0;
    logic [MW-1:0]         frac_n_p0;
    logic                  g_n_p0, r_n_p0, s_n_p0, zero_n_p0, unf_n_p0, sign_n_p0;

    assign carry_p0    = I_Mantissa[MW+1];
    assign lz_p0       = lzc(I_Mantissa[MW:0]);
    assign exp_in_p0   = $signed({2'b00, I_Exp});
    assign lz_s_p0     = $signed({{(IEW-LZW){1'b0}}, lz_p0});
    // G then R refill the vacated low bits; the hidden bit falls off the top.
    assign frac_shl_p0 = MW'(({I_Mantissa[MW-1:0], I_Guard, I_Round} << lz_p0) >> 2);

    always_comb begin
        exp_n_p0  = exp_in_p0;
        frac_n_p0 = I_Mantissa[MW-1:0];
        g_n_p0    = I_Guard;
        r_n_p0    = I_Round;
        s_n_p0    = I_Sticky;
        zero_n_p0 = 1'b0;
        unf_n_p0  = 1'b0;
        sign_n_p0 = I_Sign;
        if (carry_p0) begin
            exp_n_p0  = exp_in_p0 + EXP_ONE;
            frac_n_p0 = I_Mantissa[MW:1];
            g_n_p0    = I_Mantissa[0];
            r_n_p0    = I_Guard;
            s_n_p0    = I_Round | I_Sticky;
        end else if (lz_p0 != '0) begin
            if (lz_p0 == LZW'(MW + 1) && !(I_Guard | I_Round | I_Sticky)) begin
                zero_n_p0 = 1'b1;
                sign_n_p0 = 1'b0;
            end else begin
                exp_n_p0  = exp_in_p0 - lz_s_p0;
                frac_n_p0 = frac_shl_p0;
                g_n_p0    = 1'b0;
                r_n_p0    = 1'b0;
                unf_n_p0  = (exp_in_p0 - lz_s_p0) < EXP_ONE;
            end
        end
    end

    // ---- stage 1 registers ----
    logic                  vld_p1;
    logic                  sign_p1, g_p1, r_p1, s_p1, zero_p1, unf_p1;
    logic signed [IEW-1:0] exp_p1;
    logic [MW-1:0]         frac_p1;

    always_ff @(posedge I_Clk or negedge I_nReset) begin
        if (!I_nReset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= I_Valid;
        end
    end

    always_ff @(posedge I_Clk or negedge I_nReset) begin
        if (!I_nReset) begin
            sign_p1 <= 1'b0;
            exp_p1  <= '0;
            frac_p1 <= '0;
            g_p1    <= 1'b0;
            r_p1    <= 1'b0;
            s_p1    <= 1'b0;
            zero_p1 <= 1'b0;
            unf_p1  <= 1'b0;
        end else if (I_Valid) begin
            sign_p1 <= sign_n_p0;
            exp_p1  <= exp_n_p0;
            frac_p1 <= frac_n_p0;
            g_p1    <= g_n_p0;
            r_p1    <= r_n_p0;
            s_p1    <= s_n_p0;
            zero_p1 <= zero_n_p0;
            unf_p1  <= unf_n_p0;
        end
    end

    logic [MW:0]            rnd_p1;
    logic signed [IEW-1:0]  exp_rnd_p1;
    logic [PRECISION-1:0]   result_n_p1;
    logic                   ovf_n_p1, unf_n_p1, inx_n_p1;

    assign rnd_p1     = round_frac(frac_p1, g_p1, r_p1, s_p1);
    assign exp_rnd_p1 = exp_p1 + $signed({{(IEW-1){1'b0}}, rnd_p1[MW]});

    always_comb begin
        result_n_p1 = {sign_p1, exp_rnd_p1[EW-1:0], rnd_p1[MW-1:0]};
        ovf_n_p1    = 1'b0;
        unf_n_p1    = 1'b0;
        inx_n_p1    = g_p1 | r_p1 | s_p1;
        if (zero_p1) begin
            result_n_p1 = '0;
            inx_n_p1    = 1'b0;
        end else if (unf_p1) begin
            result_n_p1 = {sign_p1, {(PRECISION-1){1'b0}}};
            unf_n_p1    = 1'b1;
            inx_n_p1    = 1'b1;
        end else if (saturates(exp_rnd_p1)) begin
            result_n_p1 = {sign_p1, {EW{1'b1}}, {MW{1'b0}}};
            ovf_n_p1    = 1'b1;
            inx_n_p1    = 1'b1;
        end
    end

    // ---- stage 2 registers ----
    logic                 vld_p2;
    logic [PRECISION-1:0] result_p2;
    logic                 ovf_p2, unf_p2, inx_p2;

    always_ff @(posedge I_Clk or negedge I_nReset) begin
        if (!I_nReset) begin
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge I_Clk or negedge I_nReset) begin
        if (!I_nReset) begin
            result_p2 <= '0;
            ovf_p2    <= 1'b0;
            unf_p2    <= 1'b0;
            inx_p2    <= 1'b0;
        end else if (vld_p1) begin
            result_p2 <= result_n_p1;
            ovf_p2    <= ovf_n_p1;
            unf_p2    <= unf_n_p1;
            inx_p2    <= inx_n_p1;
        end
    end

    assign O_PostNorm_Valid     = vld_p2;
    assign O_PostNorm_Result    = result_p2;
    assign O_PostNorm_Overflow  = ovf_p2;
    assign O_PostNorm_Underflow = unf_p2;
    assign O_PostNorm_Inexact   = inx_p2;

endmodule
